wb_unit: RTL and testbench
==========================

# wb_unit

Writeback unit that drives the register file's write port (`regCtrl_wen`, `regCtrl_rdAddr`, `rdData`). It arbitrates completed results from the execute unit (EXU) and the load/store unit (LSU), sign- or zero-extends load data, and keeps a 32-entry busy scoreboard consumed by issue. It also maintains a retired-result counter. It sits between EXU/LSU and the register file, one pipeline register ahead of the register file write.

## Interface
Parameters:
- `XLEN`, 64, data width.
- `STARVE_LIMIT`, 4, consecutive EXU-denied cycles before EXU is forced priority.

Ports:
- `clock`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-high reset.
- `exu_valid`  in  1  EXU result valid.
- `exu_ready`  out  1  EXU result accepted this cycle when high with `exu_valid`.
- `exu_wen`  in  1  EXU result writes a register.
- `exu_rdAddr`  in  5  EXU destination.
- `exu_data`  in  XLEN  EXU result.
- `lsu_valid`  in  1  load result valid.
- `lsu_ready`  out  1  load result accepted.
- `lsu_rdAddr`  in  5  load destination (always writes).
- `lsu_data`  in  XLEN  raw load data, right-aligned.
- `lsu_size`  in  2  0 = byte, 1 = half, 2 = word, 3 = dword.
- `lsu_unsigned`  in  1  zero-extend when high, otherwise sign-extend.
- `issue_valid`  in  1  issue reserves `issue_rdAddr`.
- `issue_rdAddr`  in  5  register being reserved.
- `regCtrl_wen`  out  1  register file write enable (registered).
- `regCtrl_rdAddr`  out  5  register file write address (registered).
- `rdData`  out  XLEN  register file write data (registered).
- `busy`  out  32  scoreboard; bit i high means xi has a pending producer.
- `instret`  out  64  count of accepted results.
- `hazard_err`  out  1  sticky; issue reserved an already-busy register.

## Operation
- Arbitration: LSU has priority by default.
  - `lsu_ready = !force_exu`.
  - `exu_ready = force_exu | !lsu_valid`.
- Starvation counter, 3 bits:
  - Increments each cycle `exu_valid & lsu_valid & !force_exu`.
  - Clears on any EXU acceptance or when `exu_valid` is low.
  - `force_exu` is high for exactly one cycle when the counter reaches `STARVE_LIMIT`; it then clears.
- Load extension: take the low 8/16/32/64 bits per `lsu_size`, then extend. Sign extension uses the top bit of the selected field; zero extension when `lsu_unsigned` is high. Size 3 passes through unchanged.
- Accepted result with destination x0, or EXU result with `exu_wen` low:
  - `regCtrl_wen` stays low.
  - `instret` still increments.
  - No busy bit changes.
- Scoreboard:
  - Set bit i on `issue_valid` with `issue_rdAddr == i`, for i ≠ 0.
  - Clear bit i on the edge that registers a write to i. The bit is low from the cycle `regCtrl_wen` asserts for i.
  - Set and clear of the same bit in the same cycle: set wins.
  - `busy[0]` is always 0.
- `hazard_err` sets when `issue_valid` targets a register whose busy bit is already 1 (i ≠ 0). It clears only on reset.
- `instret` increments by 1 per accepted handshake (at most one per cycle) and wraps at 2^64.

## Timing
- Handshake accepted in cycle N: in cycle N+1 `regCtrl_wen`, `regCtrl_rdAddr` and `rdData` present the result. The register file writes on the N+1→N+2 edge.
- When nothing is accepted, `regCtrl_wen` is 0 the next cycle. `regCtrl_rdAddr` and `rdData` hold their last values.
- `exu_ready` and `lsu_ready` are combinational from `lsu_valid`, `exu_valid` and `force_exu`. No throughput loss: one result per cycle.
- Reset values: all registered outputs, `busy`, `instret`, `hazard_err` and the starvation counter are 0.
- Reset asserted mid-operation:
  - Outputs go to reset values immediately (asynchronous).
  - An in-flight result is dropped; the register file is not written.
  - `exu_ready` and `lsu_ready` are held low while reset is high.

## Test plan
- EXU-only, x5 ← 0x1234: accepted cycle N → `regCtrl_wen=1`, `regCtrl_rdAddr=5`, `rdData=0x1234` in N+1; `instret=1`.
- LSU byte load of 0x...80, signed, to x7 → `rdData=0xFFFFFFFFFFFFFF80`. Same with `lsu_unsigned=1` → 0x80. Half load of 0x8001 signed → 0xFFFFFFFFFFFF8001.
- EXU and LSU both valid for 6 cycles → LSU wins cycles 0–3, EXU forced in cycle 4 (`lsu_ready=0`), LSU wins cycle 5.
- Issue reserves x3 in cycle 0 → `busy[3]=1` from cycle 1. EXU result to x3 accepted in cycle 2 → `busy[3]=0` from cycle 3. Reserve x3 again in the same cycle as the clear → bit stays 1.
- Result to x0 with data 0xFF → `regCtrl_wen` stays 0, `busy` unchanged, `instret` increments. Reserving busy x9 again → `hazard_err=1` until reset.
- Assert reset the cycle after an accept → `regCtrl_wen=0`, `busy=0`, `instret=0` immediately.

Source files
------------

// File: rtl/wb_unit_if.sv
// Writeback bus bundle: EXU/LSU result channels, issue reservation, register-file write port and status.
interface wb_unit_if #(parameter int XLEN = 64);
    logic            exu_valid;
    logic            exu_ready;
    logic            exu_wen;
    logic [4:0]      exu_rdAddr;
    logic [XLEN-1:0] exu_data;
    logic            lsu_valid;
    logic            lsu_ready;
    logic [4:0]      lsu_rdAddr;
    logic [XLEN-1:0] lsu_data;
    logic [1:0]      lsu_size;
    logic            lsu_unsigned;
    logic            issue_valid;
    logic [4:0]      issue_rdAddr;
    logic            regCtrl_wen;
    logic [4:0]      regCtrl_rdAddr;
    logic [XLEN-1:0] rdData;
    logic [31:0]     busy;
    logic [63:0]     instret;
    logic            hazard_err;

    modport master (
        output exu_valid, exu_wen, exu_rdAddr, exu_data,
        output lsu_valid, lsu_rdAddr, lsu_data, lsu_size, lsu_unsigned,
        output issue_valid, issue_rdAddr,
        input  exu_ready, lsu_ready,
        input  regCtrl_wen, regCtrl_rdAddr, rdData, busy, instret, hazard_err
    );

    modport slave (
        input  exu_valid, exu_wen, exu_rdAddr, exu_data,
        input  lsu_valid, lsu_rdAddr, lsu_data, lsu_size, lsu_unsigned,
        input  issue_valid, issue_rdAddr,
        output exu_ready, lsu_ready,
        output regCtrl_wen, regCtrl_rdAddr, rdData, busy, instret, hazard_err
    );
endinterface

// File: rtl/wb_unit.sv
// Writeback unit: arbitrates EXU/LSU results into one registered register-file write,
// extends load data, tracks a busy scoreboard, retired count and reservation hazards.
module wb_unit #(
    parameter int XLEN         = 64,
    parameter int STARVE_LIMIT = 4
) (
    input logic       clock,
    input logic       reset,
    wb_unit_if.slave  bus
);
    logic [2:0]      starve_cnt;
    logic            force_exu;
    logic            exu_acc;
    logic            lsu_acc;
    logic            acc;
    logic            acc_wen;
    logic            sel_wen;
    logic [4:0]      acc_addr;
    logic [XLEN-1:0] acc_data;
    logic [XLEN-1:0] load_ext;
    logic [31:0]     set_mask;
    logic [31:0]     clr_mask;
    logic [31:0]     busy_nxt;

    logic            wen_q;
    logic [4:0]      addr_q;
    logic [XLEN-1:0] data_q;
    logic [31:0]     busy_q;
    logic [63:0]     instret_q;
    logic            hazard_q;

    assign force_exu     = (starve_cnt == 3'(STARVE_LIMIT));
    // Ready lines are forced low during reset so nothing handshakes while the unit is cleared.
    assign bus.lsu_ready = !reset && !force_exu;
    assign bus.exu_ready = !reset && (force_exu || !bus.lsu_valid);
    assign lsu_acc       = bus.lsu_valid && bus.lsu_ready;
    assign exu_acc       = bus.exu_valid && bus.exu_ready;
    assign acc           = lsu_acc || exu_acc;

    always_comb begin
        load_ext = bus.lsu_data;
        case (bus.lsu_size)
            2'd0: load_ext = bus.lsu_unsigned ? {{(XLEN-8){1'b0}}, bus.lsu_data[7:0]}
                                              : {{(XLEN-8){bus.lsu_data[7]}}, bus.lsu_data[7:0]};
            2'd1: load_ext = bus.lsu_unsigned ? {{(XLEN-16){1'b0}}, bus.lsu_data[15:0]}
                                              : {{(XLEN-16){bus.lsu_data[15]}}, bus.lsu_data[15:0]};
            2'd2: load_ext = bus.lsu_unsigned ? {{(XLEN-32){1'b0}}, bus.lsu_data[31:0]}
                                              : {{(XLEN-32){bus.lsu_data[31]}}, bus.lsu_data[31:0]};
            default: load_ext = bus.lsu_data;
        endcase
    end

    // The two acceptances are mutually exclusive by construction of the ready lines.
    always_comb begin
        acc_addr = bus.exu_rdAddr;
        acc_data = bus.exu_data;
        sel_wen  = bus.exu_wen;
        if (lsu_acc) begin
            acc_addr = bus.lsu_rdAddr;
            acc_data = load_ext;
            sel_wen  = 1'b1;
        end
        acc_wen  = acc && sel_wen && (acc_addr != 5'd0);
    end

    always_comb begin
        set_mask = 32'd0;
        clr_mask = 32'd0;
        if (bus.issue_valid && bus.issue_rdAddr != 5'd0)
            set_mask = 32'd1 << bus.issue_rdAddr;
        if (acc_wen)
            clr_mask = 32'd1 << acc_addr;
        busy_nxt = ((busy_q & ~clr_mask) | set_mask) & ~32'd1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wen_q      <= 1'b0;
            addr_q     <= 5'd0;
            data_q     <= '0;
            busy_q     <= 32'd0;
            instret_q  <= 64'd0;
            hazard_q   <= 1'b0;
            starve_cnt <= 3'd0;
        end else begin
            wen_q  <= acc_wen;
            busy_q <= busy_nxt;
            if (acc) begin
                addr_q    <= acc_addr;
                data_q    <= acc_data;
                instret_q <= instret_q + 64'd1;
            end
            if (bus.issue_valid && bus.issue_rdAddr != 5'd0 && busy_q[bus.issue_rdAddr])
                hazard_q <= 1'b1;
            if (exu_acc || !bus.exu_valid)
                starve_cnt <= 3'd0;
            else if (bus.lsu_valid && !force_exu)
                starve_cnt <= starve_cnt + 3'd1;
        end
    end

    assign bus.regCtrl_wen    = wen_q;
    assign bus.regCtrl_rdAddr = addr_q;
    assign bus.rdData         = data_q;
    assign bus.busy           = busy_q;
    assign bus.instret        = instret_q;
    assign bus.hazard_err     = hazard_q;
endmodule

// File: tb/tb_wb_unit.sv
// Bench for wb_unit: load-extension vector table, hand sequences for arbitration, scoreboard
// and reset corners, then random traffic checked against a behavioural model.
module tb_wb_unit;
    localparam int LIM = 4;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    wb_unit_if #(.XLEN(64)) bus ();
    wb_unit #(.XLEN(64), .STARVE_LIMIT(LIM)) dut (.clock(clock), .reset(reset), .bus(bus));

    int total = 0;
    int bad   = 0;

    // reference model state
    int          m_streak;
    logic [31:0] m_busy;
    logic [63:0] m_instret;
    logic        m_haz;
    logic        m_wen;
    logic [4:0]  m_addr;
    logic [63:0] m_data;

    typedef struct {
        logic [1:0]  size;
        logic        uns;
        logic [63:0] data;
        logic [63:0] exp;
    } ld_vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_ext(input logic [63:0] d, input logic [1:0] size, input logic uns);
        int bits;
        logic [63:0] mask, f;
        bits = 8 << size;
        if (bits == 64) return d;
        mask = (64'd1 << bits) - 64'd1;
        f = d & mask;
        if (!uns && f[bits-1]) f = f | ~mask;
        return f;
    endfunction

    task automatic clear_inputs();
        bus.exu_valid = 0; bus.exu_wen = 0; bus.exu_rdAddr = 0; bus.exu_data = 0;
        bus.lsu_valid = 0; bus.lsu_rdAddr = 0; bus.lsu_data = 0; bus.lsu_size = 0;
        bus.lsu_unsigned = 0; bus.issue_valid = 0; bus.issue_rdAddr = 0;
    endtask

    task automatic model_reset();
        m_streak = 0; m_busy = 0; m_instret = 0; m_haz = 0;
        m_wen = 0; m_addr = 0; m_data = 0;
    endtask

    task automatic check_outputs();
        chk("regCtrl_wen", bus.regCtrl_wen, m_wen);
        if (m_wen) begin
            chk("regCtrl_rdAddr", bus.regCtrl_rdAddr, m_addr);
            chk("rdData", bus.rdData, m_data);
        end
        chk("busy", bus.busy, m_busy);
        chk("instret", bus.instret, m_instret);
        chk("hazard_err", bus.hazard_err, m_haz);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        model_reset();
        #1;
        check_outputs();
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    // one clock with the currently driven inputs; checks readies, then the registered result
    task automatic run_cycle();
        logic force_e, lacc, eacc, w;
        logic [4:0]  a;
        logic [63:0] d;
        #1;
        force_e = (m_streak == LIM);
        chk("lsu_ready", bus.lsu_ready, !force_e);
        chk("exu_ready", bus.exu_ready, force_e || !bus.lsu_valid);
        lacc = bus.lsu_valid && !force_e;
        eacc = bus.exu_valid && (force_e || !bus.lsu_valid);
        w = 0; a = 0; d = 0;
        if (lacc) begin
            a = bus.lsu_rdAddr; d = ref_ext(bus.lsu_data, bus.lsu_size, bus.lsu_unsigned); w = (a != 0);
        end else if (eacc) begin
            a = bus.exu_rdAddr; d = bus.exu_data; w = bus.exu_wen && (a != 0);
        end
        m_streak = (bus.exu_valid && !eacc) ? m_streak + 1 : 0;
        if (bus.issue_valid && bus.issue_rdAddr != 0 && m_busy[bus.issue_rdAddr]) m_haz = 1;
        if (w) m_busy[a] = 1'b0;
        if (bus.issue_valid && bus.issue_rdAddr != 0) m_busy[bus.issue_rdAddr] = 1'b1;
        if (lacc || eacc) m_instret = m_instret + 64'd1;
        m_wen = w;
        if (w) begin m_addr = a; m_data = d; end
        @(posedge clock);
        #1;
        check_outputs();
    endtask

    initial begin
        ld_vec_t vecs[9];
        logic [5:0] starve_exp;
        vecs[0] = '{2'd0, 1'b0, 64'h0000_0000_0000_0080, 64'hFFFF_FFFF_FFFF_FF80};
        vecs[1] = '{2'd0, 1'b1, 64'h0000_0000_0000_0080, 64'h0000_0000_0000_0080};
        vecs[2] = '{2'd1, 1'b0, 64'h0000_0000_0000_8001, 64'hFFFF_FFFF_FFFF_8001};
        vecs[3] = '{2'd1, 1'b1, 64'h0000_0000_0000_8001, 64'h0000_0000_0000_8001};
        vecs[4] = '{2'd2, 1'b0, 64'h1234_5678_8000_0000, 64'hFFFF_FFFF_8000_0000};
        vecs[5] = '{2'd2, 1'b1, 64'h1234_5678_8000_0000, 64'h0000_0000_8000_0000};
        vecs[6] = '{2'd3, 1'b0, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001};
        vecs[7] = '{2'd0, 1'b0, 64'h0000_0000_0000_AB7F, 64'h0000_0000_0000_007F};
        vecs[8] = '{2'd1, 1'b0, 64'h0000_0000_FFFF_7FFF, 64'h0000_0000_0000_7FFF};

        clear_inputs();
        apply_reset();

        // EXU-only write of x5
        bus.exu_valid = 1; bus.exu_wen = 1; bus.exu_rdAddr = 5; bus.exu_data = 64'h1234;
        run_cycle();
        chk("exu_x5_wen", bus.regCtrl_wen, 1);
        chk("exu_x5_addr", bus.regCtrl_rdAddr, 5);
        chk("exu_x5_data", bus.rdData, 64'h1234);
        chk("exu_x5_instret", bus.instret, 1);
        clear_inputs();
        run_cycle();
        chk("idle_wen", bus.regCtrl_wen, 0);

        // load extension table
        foreach (vecs[i]) begin
            clear_inputs();
            bus.lsu_valid = 1; bus.lsu_rdAddr = 7;
            bus.lsu_size = vecs[i].size; bus.lsu_unsigned = vecs[i].uns; bus.lsu_data = vecs[i].data;
            run_cycle();
            chk($sformatf("load_ext[%0d]", i), bus.rdData, vecs[i].exp);
        end

        // starvation: both valid six cycles; EXU forced on the fifth
        clear_inputs();
        starve_exp = 6'b101111;
        bus.exu_valid = 1; bus.exu_wen = 1; bus.exu_rdAddr = 10; bus.exu_data = 64'hE0E0;
        bus.lsu_valid = 1; bus.lsu_rdAddr = 11; bus.lsu_size = 3; bus.lsu_data = 64'hA5A5;
        for (int c = 0; c < 6; c++) begin
            #1 chk($sformatf("starve_lsu_ready[%0d]", c), bus.lsu_ready, starve_exp[c]);
            run_cycle();
            chk($sformatf("starve_addr[%0d]", c), bus.regCtrl_rdAddr, (c == 4) ? 10 : 11);
        end

        // scoreboard set / clear / set-wins
        clear_inputs();
        apply_reset();
        bus.issue_valid = 1; bus.issue_rdAddr = 3;
        run_cycle();
        clear_inputs();
        chk("busy3_set", bus.busy[3], 1);
        run_cycle();
        bus.exu_valid = 1; bus.exu_wen = 1; bus.exu_rdAddr = 3; bus.exu_data = 64'h33;
        run_cycle();
        chk("busy3_clear", bus.busy[3], 0);
        bus.issue_valid = 1; bus.issue_rdAddr = 3; bus.exu_valid = 0;
        run_cycle();
        bus.exu_valid = 1; bus.issue_valid = 1;
        run_cycle();
        chk("busy3_set_wins", bus.busy[3], 1);
        chk("busy3_set_wins_wen", bus.regCtrl_wen, 1);

        // x0 destination and hazard detection
        clear_inputs();
        apply_reset();
        bus.exu_valid = 1; bus.exu_wen = 1; bus.exu_rdAddr = 0; bus.exu_data = 64'hFF;
        run_cycle();
        chk("x0_wen", bus.regCtrl_wen, 0);
        chk("x0_busy", bus.busy, 0);
        chk("x0_instret", bus.instret, 1);
        clear_inputs();
        bus.issue_valid = 1; bus.issue_rdAddr = 9;
        run_cycle();
        chk("haz_first", bus.hazard_err, 0);
        run_cycle();
        chk("haz_second", bus.hazard_err, 1);
        clear_inputs();
        repeat (3) run_cycle();
        chk("haz_sticky", bus.hazard_err, 1);

        // reset the cycle after an accept
        bus.exu_valid = 1; bus.exu_wen = 1; bus.exu_rdAddr = 5; bus.exu_data = 64'h55;
        bus.lsu_valid = 1; bus.lsu_rdAddr = 6;
        run_cycle();
        chk("pre_reset_wen", bus.regCtrl_wen, 1);
        reset = 1'b1;
        #1;
        chk("rst_wen", bus.regCtrl_wen, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_instret", bus.instret, 0);
        chk("rst_hazard", bus.hazard_err, 0);
        chk("rst_exu_ready", bus.exu_ready, 0);
        chk("rst_lsu_ready", bus.lsu_ready, 0);
        model_reset();
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        clear_inputs();
        run_cycle();
        chk("post_reset_wen", bus.regCtrl_wen, 0);

        // random traffic against the model
        for (int n = 0; n < 600; n++) begin
            bus.exu_valid    = ($urandom_range(0, 9) < 7);
            bus.exu_wen      = ($urandom_range(0, 9) < 8);
            bus.exu_rdAddr   = 5'($urandom_range(0, 31));
            bus.exu_data     = {$urandom, $urandom};
            bus.lsu_valid    = ($urandom_range(0, 9) < 7);
            bus.lsu_rdAddr   = 5'($urandom_range(0, 31));
            bus.lsu_data     = {$urandom, $urandom};
            bus.lsu_size     = 2'($urandom_range(0, 3));
            bus.lsu_unsigned = 1'($urandom_range(0, 1));
            bus.issue_valid  = ($urandom_range(0, 9) < 3);
            bus.issue_rdAddr = 5'($urandom_range(0, 31));
            run_cycle();
            if (n == 300) begin
                clear_inputs();
                apply_reset();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout act=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
